modport_dut: RTL and testbench

MODPORT_DUT -- requirements
Module: modport_dut

---
 rtl/modport_dut.sv | 104 ++++++++++
 tb/tb_modport_dut.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/modport_dut.sv
// Reset sequencer: drives a registered active-low reset downstream for a
// programmable number of cycles, waits a fixed settle time after release,
// then pulses a done flag and bumps a completion counter. A power-on sequence
// runs automatically after the block reset is released.
module modport_dut #(
  parameter int unsigned DEFAULT_LEN = 16,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rst_req_i,
  input  logic [7:0]  rst_len_i,
  output logic        reset_n_o,
  output logic        rst_busy_o,
  output logic        rst_done_o,
  output logic [15:0] rst_count_o
);

  typedef enum logic [1:0] {
    StAssert = 2'd0,
    StSettle = 2'd1,
    StIdle   = 2'd2
  } state_e;

  // Counter preload values: the counter runs down to zero inclusive, so a
  // phase of N cycles loads N-1.
  localparam logic [7:0] AssertInit = 8'(DEFAULT_LEN - 1);
  localparam logic [7:0] SettleInit = 8'(RELEASE_DLY - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        reset_n_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] count_q;

  logic        cnt_zero;
  logic        seq_done;
  logic [7:0]  req_cnt;

  // Decode of the current phase end and of the requested assertion length.
  always_comb begin
    cnt_zero = (cnt_q == 8'd0);
    seq_done = (state_q == StSettle) && cnt_zero;
    req_cnt  = (rst_len_i == 8'd0) ? AssertInit : (rst_len_i - 8'd1);
  end

  // Sequencer FSM with registered outputs; block reset overrides everything,
  // including a same-cycle request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StAssert;
      cnt_q     <= AssertInit;
      reset_n_q <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      // Done and the completion count follow the SETTLE->IDLE transition.
      done_q  <= seq_done;
      count_q <= count_q + 16'(seq_done);
      unique case (state_q)
        StAssert: begin
          if (cnt_zero) begin
            state_q   <= StSettle;
            cnt_q     <= SettleInit;
            reset_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StSettle: begin
          if (cnt_zero) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StIdle: begin
          // Requests are only honoured here; ASSERT/SETTLE ignore them.
          if (rst_req_i) begin
            state_q   <= StAssert;
            cnt_q     <= req_cnt;
            reset_n_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= StAssert;
          cnt_q     <= AssertInit;
          reset_n_q <= 1'b0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign reset_n_o   = reset_n_q;
  assign rst_busy_o  = busy_q;
  assign rst_done_o  = done_q;
  assign rst_count_o = count_q;

endmodule

// File: tb/tb_modport_dut.sv
// Bench for the reset sequencer. Stimulus pushes the expected completion of
// each sequence into a queue; a monitor pops on every done pulse and checks
// count, assertion length, settle length and completion cycle.
module tb_modport_dut;

  localparam int DefLen = 16;
  localparam int RelDly = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        rst_req_i;
  logic [7:0]  rst_len_i;
  logic        reset_n_o;
  logic        rst_busy_o;
  logic        rst_done_o;
  logic [15:0] rst_count_o;

  typedef struct {
    logic [15:0] count;
    int          low_len;
    int          done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] exp_count = 16'd0;
  int          k0;

  modport_dut #(
    .DEFAULT_LEN(DefLen),
    .RELEASE_DLY(RelDly)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rst_req_i  (rst_req_i),
    .rst_len_i  (rst_len_i),
    .reset_n_o  (reset_n_o),
    .rst_busy_o (rst_busy_o),
    .rst_done_o (rst_done_o),
    .rst_count_o(rst_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge number: after rising edge k, cyc == k.
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin : monitor
    int   low_run;
    int   settle_run;
    int   last_low;
    logic prev_n;
    exp_t e;
    low_run = 0;
    settle_run = 0;
    last_low = 0;
    prev_n = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (reset_i) begin
        check("rst_reset_n", 32'(reset_n_o), 32'd0);
        check("rst_busy", 32'(rst_busy_o), 32'd1);
        check("rst_done", 32'(rst_done_o), 32'd0);
        check("rst_count", 32'(rst_count_o), 32'd0);
        low_run = 0;
        settle_run = 0;
        prev_n = 1'b0;
      end
      if (!reset_n_o) begin
        low_run++;
        check("busy_in_assert", 32'(rst_busy_o), 32'd1);
      end else if (rst_busy_o) begin
        settle_run++;
      end
      if (reset_n_o && !prev_n) begin
        last_low = low_run;
        low_run = 0;
      end
      prev_n = reset_n_o;
      if (rst_done_o && !reset_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done pulse, expected none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_count", 32'(rst_count_o), 32'(e.count));
          check("assert_len", 32'(last_low), 32'(e.low_len));
          check("settle_len", 32'(settle_run), 32'(RelDly));
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("done_busy", 32'(rst_busy_o), 32'd0);
        end
        settle_run = 0;
      end
    end
  end

  task automatic request(input logic [7:0] len, input bit expect_done, output int edge_no);
    int eff;
    @(negedge clk_i);
    rst_req_i = 1'b1;
    rst_len_i = len;
    edge_no = cyc + 1;
    eff = (len == 8'd0) ? DefLen : int'(len);
    if (expect_done) begin
      exp_count = exp_count + 16'd1;
      exp_q.push_back('{exp_count, eff, edge_no + eff + RelDly});
    end
    @(negedge clk_i);
    rst_req_i = 1'b0;
    rst_len_i = 8'h5A;
  endtask

  // Called at the negedge just after reset_i is dropped; cyc is the last reset edge.
  task automatic push_power_on();
    exp_count = 16'd1;
    exp_q.push_back('{16'd1, DefLen, cyc + DefLen + RelDly});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending completions, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    check({name, "_idle_reset_n"}, 32'(reset_n_o), 32'd1);
    check({name, "_idle_busy"}, 32'(rst_busy_o), 32'd0);
    check({name, "_idle_done"}, 32'(rst_done_o), 32'd0);
  endtask

  initial begin : stimulus
    int n;
    reset_i = 1'b1;
    rst_req_i = 1'b0;
    rst_len_i = 8'd0;

    // Power-on: reset held for 5 edges.
    repeat (5) @(negedge clk_i);
    reset_i = 1'b0;
    push_power_on();
    drain("power_on");

    // Short requested sequence.
    request(8'd3, 1'b1, k0);
    drain("len3");

    // Default length; repeated requests during ASSERT and SETTLE are ignored.
    request(8'd0, 1'b1, k0);
    repeat (2) @(negedge clk_i);
    rst_req_i = 1'b1;
    rst_len_i = 8'd5;
    repeat (3) @(negedge clk_i);
    rst_req_i = 1'b0;
    repeat (12) @(negedge clk_i);
    rst_req_i = 1'b1;
    rst_len_i = 8'd1;
    @(negedge clk_i);
    rst_req_i = 1'b0;

    // Request in the done cycle.
    n = 0;
    while (n < 100) begin
      @(posedge clk_i);
      #1;
      if (rst_done_o) break;
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL wait_done: got no done pulse within 100 cycles, expected one");
    end
    request(8'd2, 1'b1, k0);
    drain("back_to_back");

    // Abort a requested sequence during SETTLE with a one-cycle block reset.
    request(8'd5, 1'b0, k0);
    repeat (5) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    push_power_on();
    drain("abort");

    // Block reset wins over a same-cycle request in IDLE.
    @(negedge clk_i);
    reset_i = 1'b1;
    rst_req_i = 1'b1;
    rst_len_i = 8'd3;
    @(negedge clk_i);
    reset_i = 1'b0;
    rst_req_i = 1'b0;
    push_power_on();
    drain("priority");

    // Counter wrap: preload 0xFFFF, next completion reads 0x0000.
    @(negedge clk_i);
    force dut.count_q = 16'hFFFF;
    @(negedge clk_i);
    release dut.count_q;
    exp_count = 16'hFFFF;
    request(8'd1, 1'b1, k0);
    drain("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000 time units");
    $fatal(1);
  end

endmodule
